pwmdecoder_multi_wb: RTL and testbench
======================================

Name: pwmdecoder_multi_wb

Overview:
- Parametrised successor to the 6-channel RC PWM decoder.
- Decodes NUM_CH RC-style PWM inputs using an internal per-channel measurement engine.
- Adds configurable pulse-range limits, signal-loss timeout, sticky error flags, new-sample flags and a maskable interrupt.
- Sits on the Wishbone B3 peripheral bus next to the motor/ESC blocks of the SPI quadcopter design.

Parameters:
- CLK_FREQ, 100_000_000, system clock in Hz; must be an integer multiple of 1_000_000.
- NUM_CH, 8, number of PWM input channels, 1..16.
- DATA_WIDTH, 32, Wishbone data width; only 32 is supported.
- ADDR_WIDTH, 32, Wishbone address width.
- SELECT_WIDTH, DATA_WIDTH/8, Wishbone byte-select width.
- SYNC_STAGES, 2, input synchroniser depth, 2..4.
- MAX_PULSE_US, 2500, a high time reaching this value is a long-pulse error.
- TIMEOUT_US, 25000, a period with no rising edge for this long is signal loss.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous, active-high reset.
- wb_adr_i  in  ADDR_WIDTH  byte address; bits [6:2] decode the register.
- wb_dat_i  in  DATA_WIDTH  write data.
- wb_dat_o  out  DATA_WIDTH  read data.
- wb_we_i  in  1  write enable.
- wb_sel_i  in  SELECT_WIDTH  byte selects.
- wb_stb_i  in  1  strobe.
- wb_cyc_i  in  1  cycle.
- wb_ack_o  out  1  acknowledge.
- wb_err_o  out  1  tied to 0.
- wb_rty_o  out  1  tied to 0.
- i_pwm  in  NUM_CH  PWM inputs; bit n is channel n.
- o_irq  out  1  level interrupt, equal to OR of (NEW & IRQ_EN).

Behaviour:
- Reset: one clock and one reset; reset is synchronous and active-high. While i_rst is high, all outputs and registers go to 0: wb_dat_o=0, wb_ack_o=0, o_irq=0, all VALUE, STATUS, NEW, ERR and IRQ_EN registers = 0. Synchronisers, prescaler and channel FSMs return to IDLE. A pulse in progress when reset asserts is discarded.
- Microsecond tick: one shared prescaler counts 0..CLK_FREQ/1e6-1 and asserts us_tick for one cycle at the terminal count.
- Per-channel input path: SYNC_STAGES flip-flop synchroniser, then a registered edge detector.
- Per-channel FSM:
  - IDLE: a rising edge clears width_cnt and goes to HIGH.
  - HIGH: width_cnt increments on us_tick, saturating at 16 bits.
    - Falling edge: VALUE=width_cnt, STATUS[n]=1, NEW[n]=1, go to LOW.
    - width_cnt reaches MAX_PULSE_US: VALUE=MAX_PULSE_US|0x8000, ERR[n]=1, STATUS[n]=0, go to WAIT_LOW.
  - WAIT_LOW: a falling edge goes to LOW; nothing else is recorded.
  - LOW: gap_cnt counts us_ticks from the last rising edge.
    - Rising edge: clear width_cnt and gap_cnt, go to HIGH.
    - gap_cnt reaches TIMEOUT_US: VALUE=0xC000, ERR[n]=1, STATUS[n]=0, go to IDLE.
  - gap_cnt also runs in IDLE after reset, so a dead input times out after TIMEOUT_US.
- Latency: VALUE updates exactly SYNC_STAGES+2 cycles after the falling edge is first sampled at i_pwm. Width resolution is ±1 us.
- Register map (word offsets; reads return zero-extended values):
  - 0x00+4n: VALUE[n], 16 bits, read-only, for n<NUM_CH.
  - 0x40: STATUS, read-only; bit n = channel has a valid, in-range sample.
  - 0x44: NEW, write-1-to-clear; set on each valid sample.
  - 0x48: ERR, sticky, write-1-to-clear; set on long pulse or timeout.
  - 0x4C: IRQ_EN, read/write.
  - 0x50: ID, constant {8'h50, 8'h57, 8'h00, NUM_CH[7:0]}.
  - Any other address, or VALUE slots with n>=NUM_CH: read 0xDEADBEEF; writes ignored.
- Write rules:
  - Byte lanes obey wb_sel_i: sel[0] covers bits 7:0, sel[1] covers bits 15:8.
  - Writes to read-only registers are acked and ignored.
  - If a W1C write and a hardware set hit the same bit in the same cycle, the set wins and the bit stays 1.
- Handshake:
  - wb_ack_o <= stb & cyc & !wb_ack_o, so each access gets a one-cycle ack and the bus cannot ack back-to-back.
  - wb_dat_o is registered and valid in the ack cycle.
  - Writes take effect in the ack cycle.
- o_irq is registered: it updates one cycle after NEW or IRQ_EN changes.

Test Plan:
- CLK_FREQ=10e6, NUM_CH=4; 1500 us high pulse on ch2 -> VALUE[2]=0x05DC (±1), STATUS[2]=1, NEW[2]=1, update at SYNC_STAGES+2 cycles after the falling edge.
- ch0 held high for 3000 us -> VALUE[0]=0x89C4, ERR[0]=1, STATUS[0]=0; the next valid 1000 us pulse -> VALUE[0]=0x03E8, ERR[0] still 1 until 0x1 is written to 0x48.
- No edges on ch1 for 25000 us after reset -> VALUE[1]=0xC000, ERR[1]=1.
- IRQ_EN=0x2, valid pulse on ch1 -> o_irq=1; write 0x2 to NEW in the same cycle a new sample lands -> NEW[1] stays 1 and o_irq stays 1.
- Read 0x10 with NUM_CH=4 -> 0xDEADBEEF; read 0x50 -> 0x50570004; hold stb/cyc for 4 cycles -> ack pattern 1,0,1,0.
- Assert i_rst mid-pulse on ch3 -> all registers 0 the next cycle; the released pulse tail is not recorded.

Source files
------------

// File: rtl/pwmdecoder_multi_wb.sv
// pwmdecoder_multi_wb: NUM_CH-channel RC PWM pulse-width decoder with range
// limits, signal-loss timeout, sticky error flags and a Wishbone B3 slave port.
//
// Channel FSM states
//   state       | meaning
//   IDLE        | no pulse tracked (after reset or after signal loss)
//   HIGH        | input high, width_cnt counting microseconds
//   WAIT_LOW    | pulse too long, waiting for the line to drop
//   LOW         | input low after a pulse, gap_cnt watching for loss
module pwmdecoder_multi_wb #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int NUM_CH       = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int SYNC_STAGES  = 2,
    parameter int MAX_PULSE_US = 2500,
    parameter int TIMEOUT_US   = 25000
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    input  logic                    wb_we_i,
    input  logic [SELECT_WIDTH-1:0] wb_sel_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_cyc_i,
    output logic                    wb_ack_o,
    output logic                    wb_err_o,
    output logic                    wb_rty_o,
    input  logic [NUM_CH-1:0]       i_pwm,
    output logic                    o_irq
);

    localparam int          DIV        = CLK_FREQ / 1_000_000;
    localparam int          PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [15:0] MAX_W      = 16'(MAX_PULSE_US);
    localparam logic [15:0] TMO        = 16'(TIMEOUT_US);
    localparam logic [15:0] LONG_CODE  = MAX_W | 16'h8000;
    localparam logic [15:0] LOST_CODE  = 16'hC000;
    localparam logic [2:0]  SETTLED    = 3'(SYNC_STAGES + 1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_HIGH     = 2'd1;
    localparam logic [1:0] ST_WAIT_LOW = 2'd2;
    localparam logic [1:0] ST_LOW      = 2'd3;

    localparam logic [4:0] IDX_STATUS = 5'd16;
    localparam logic [4:0] IDX_NEW    = 5'd17;
    localparam logic [4:0] IDX_ERR    = 5'd18;
    localparam logic [4:0] IDX_IRQ_EN = 5'd19;
    localparam logic [4:0] IDX_ID     = 5'd20;

    logic [PW-1:0]          pre_q;
    logic                   us_tick;
    logic [2:0]             settle_q;
    logic                   edge_en;

    logic [SYNC_STAGES-1:0] sync_q [NUM_CH];
    logic [NUM_CH-1:0]      lvl_q, rise_q, fall_q;

    logic [1:0]             state_q    [NUM_CH];
    logic [15:0]            width_q    [NUM_CH];
    logic [15:0]            gap_q      [NUM_CH];
    logic [15:0]            ev_value_q [NUM_CH];
    logic [NUM_CH-1:0]      lost_q, ev_valid_q, ev_err_q;

    logic [15:0]            value_q    [NUM_CH];
    logic [NUM_CH-1:0]      status_q, new_q, err_q, irq_en_q;
    logic                   ack_q, irq_q;
    logic [DATA_WIDTH-1:0]  dat_q;

    logic [4:0]             reg_idx;
    logic                   bus_access, wr_en;
    logic [NUM_CH-1:0]      wmask, wdata, new_clr, err_clr;
    logic [31:0]            rdata;
    logic                   unused_bits;

    assign us_tick = (pre_q == PW'(DIV - 1));
    assign edge_en = (settle_q == SETTLED);

    // Shared microsecond prescaler.
    always_ff @(posedge i_clk) begin
        if (i_rst)        pre_q <= '0;
        else if (us_tick) pre_q <= '0;
        else              pre_q <= pre_q + 1'b1;
    end

    // Hold off edge detection until the synchronisers carry real input levels,
    // so a line that is already high at reset release is not seen as a rising edge.
    always_ff @(posedge i_clk) begin
        if (i_rst)                settle_q <= '0;
        else if (settle_q != SETTLED) settle_q <= settle_q + 3'd1;
    end

    // Input synchronisers and registered edge detectors.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int n = 0; n < NUM_CH; n++) sync_q[n] <= '0;
            lvl_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                sync_q[n] <= {sync_q[n][SYNC_STAGES-2:0], i_pwm[n]};
                lvl_q[n]  <= sync_q[n][SYNC_STAGES-1];
                rise_q[n] <= edge_en &  sync_q[n][SYNC_STAGES-1] & ~lvl_q[n];
                fall_q[n] <= edge_en & ~sync_q[n][SYNC_STAGES-1] &  lvl_q[n];
            end
        end
    end

    // Per-channel measurement FSMs; results leave as one-cycle events.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int n = 0; n < NUM_CH; n++) begin
                state_q[n]    <= ST_IDLE;
                width_q[n]    <= '0;
                gap_q[n]      <= '0;
                ev_value_q[n] <= '0;
            end
            lost_q     <= '0;
            ev_valid_q <= '0;
            ev_err_q   <= '0;
        end else begin
            ev_valid_q <= '0;
            ev_err_q   <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                // gap saturates at the timeout so a lost channel reports only once
                if (us_tick && gap_q[n] != TMO) gap_q[n] <= gap_q[n] + 16'd1;
                case (state_q[n])
                    ST_IDLE: begin
                        if (rise_q[n]) begin
                            width_q[n] <= '0;
                            gap_q[n]   <= '0;
                            lost_q[n]  <= 1'b0;
                            state_q[n] <= ST_HIGH;
                        end else if (!lost_q[n] && gap_q[n] == TMO) begin
                            ev_err_q[n]   <= 1'b1;
                            ev_value_q[n] <= LOST_CODE;
                            lost_q[n]     <= 1'b1;
                        end
                    end
                    ST_HIGH: begin
                        if (width_q[n] >= MAX_W) begin
                            ev_err_q[n]   <= 1'b1;
                            ev_value_q[n] <= LONG_CODE;
                            state_q[n]    <= ST_WAIT_LOW;
                        end else if (fall_q[n]) begin
                            ev_valid_q[n] <= 1'b1;
                            ev_value_q[n] <= width_q[n];
                            state_q[n]    <= ST_LOW;
                        end else if (us_tick && width_q[n] != 16'hFFFF) begin
                            width_q[n] <= width_q[n] + 16'd1;
                        end
                    end
                    ST_WAIT_LOW: begin
                        if (fall_q[n]) state_q[n] <= ST_LOW;
                    end
                    ST_LOW: begin
                        if (rise_q[n]) begin
                            width_q[n] <= '0;
                            gap_q[n]   <= '0;
                            state_q[n] <= ST_HIGH;
                        end else if (gap_q[n] == TMO) begin
                            ev_err_q[n]   <= 1'b1;
                            ev_value_q[n] <= LOST_CODE;
                            lost_q[n]     <= 1'b1;
                            state_q[n]    <= ST_IDLE;
                        end
                    end
                    default: state_q[n] <= ST_IDLE;
                endcase
            end
        end
    end

    assign reg_idx    = wb_adr_i[6:2];
    assign bus_access = wb_stb_i & wb_cyc_i & ~ack_q;
    assign wr_en      = bus_access & wb_we_i;
    assign wdata      = wb_dat_i[NUM_CH-1:0];
    assign new_clr    = (wr_en && reg_idx == IDX_NEW) ? (wdata & wmask) : '0;
    assign err_clr    = (wr_en && reg_idx == IDX_ERR) ? (wdata & wmask) : '0;

    // Byte-lane mask: channel n lives in byte lane n/8.
    always_comb begin
        wmask = '0;
        for (int n = 0; n < NUM_CH; n++) wmask[n] = wb_sel_i[n/8];
    end

    // Register read multiplexer.
    always_comb begin
        rdata = 32'hDEAD_BEEF;
        for (int n = 0; n < NUM_CH; n++) begin
            if (reg_idx == 5'(n)) rdata = {16'h0000, value_q[n]};
        end
        case (reg_idx)
            IDX_STATUS: rdata = {{(32-NUM_CH){1'b0}}, status_q};
            IDX_NEW:    rdata = {{(32-NUM_CH){1'b0}}, new_q};
            IDX_ERR:    rdata = {{(32-NUM_CH){1'b0}}, err_q};
            IDX_IRQ_EN: rdata = {{(32-NUM_CH){1'b0}}, irq_en_q};
            IDX_ID:     rdata = {8'h50, 8'h57, 8'h00, 8'(NUM_CH)};
            default:    ;
        endcase
    end

    // Register file, bus handshake and interrupt; hardware sets beat W1C clears.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int n = 0; n < NUM_CH; n++) value_q[n] <= '0;
            status_q <= '0;
            new_q    <= '0;
            err_q    <= '0;
            irq_en_q <= '0;
            ack_q    <= 1'b0;
            dat_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            ack_q <= bus_access;
            if (bus_access) dat_q <= rdata;
            for (int n = 0; n < NUM_CH; n++) begin
                if (ev_valid_q[n] | ev_err_q[n]) value_q[n] <= ev_value_q[n];
            end
            status_q <= (status_q | ev_valid_q) & ~ev_err_q;
            new_q    <= (new_q & ~new_clr) | ev_valid_q;
            err_q    <= (err_q & ~err_clr) | ev_err_q;
            if (wr_en && reg_idx == IDX_IRQ_EN)
                irq_en_q <= (irq_en_q & ~wmask) | (wdata & wmask);
            irq_q <= |(new_q & irq_en_q);
        end
    end

    assign wb_dat_o = dat_q;
    assign wb_ack_o = ack_q;
    assign wb_err_o = 1'b0;
    assign wb_rty_o = 1'b0;
    assign o_irq    = irq_q;

    assign unused_bits = ^{wb_adr_i[ADDR_WIDTH-1:7], wb_adr_i[1:0], wb_sel_i, wb_dat_i};

endmodule

// File: tb/tb_pwmdecoder_multi_wb.sv
// Directed bench for pwmdecoder_multi_wb: 2 MHz clock (2 cycles per us),
// 4 channels and a 4000 us timeout keep the run short.
module tb_pwmdecoder_multi_wb;

    localparam int CLK_FREQ = 2_000_000;
    localparam int NUM_CH   = 4;
    localparam int CPU      = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       adr, dat_w;
    logic [31:0]       dat_r;
    logic              we, stb, cyc;
    logic [3:0]        sel;
    logic              ack, err, rty, irq;
    logic [NUM_CH-1:0] pwm;

    int          checks = 0;
    int          fails  = 0;
    logic        ack_seen;
    logic [31:0] rd;

    pwmdecoder_multi_wb #(
        .CLK_FREQ(CLK_FREQ), .NUM_CH(NUM_CH), .DATA_WIDTH(32), .ADDR_WIDTH(32),
        .SELECT_WIDTH(4), .SYNC_STAGES(2), .MAX_PULSE_US(2500), .TIMEOUT_US(4000)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_dat_o(dat_r), .wb_we_i(we),
        .wb_sel_i(sel), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_ack_o(ack),
        .wb_err_o(err), .wb_rty_o(rty), .i_pwm(pwm), .o_irq(irq)
    );

    always #5 clk = ~clk;

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        adr = a; dat_w = d; sel = s; we = 1'b1; stb = 1'b1; cyc = 1'b1;
        @(negedge clk);
        ack_seen = ack;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        adr = a; sel = 4'hF; we = 1'b0; stb = 1'b1; cyc = 1'b1;
        @(negedge clk);
        d = dat_r;
        ack_seen = ack;
        stb = 1'b0; cyc = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic pulse(input int ch, input int us);
        @(negedge clk); pwm[ch] = 1'b1;
        repeat (us * CPU) @(negedge clk);
        pwm[ch] = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; pwm = '0; adr = '0; dat_w = '0; we = 0; stb = 0; cyc = 0; sel = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if ({ack, irq, err, rty} !== 4'b0000) begin fails++; $display("FAIL reset_outputs: got %b expected 0000", {ack, irq, err, rty}); end
        checks++; if (dat_r !== 32'h0) begin fails++; $display("FAIL reset_dat: got %h expected 00000000", dat_r); end
        rst = 1'b0;
        repeat (10) @(negedge clk);
        wb_read(32'h40, rd);
        checks++; if (rd !== 32'h0) begin fails++; $display("FAIL reset_status: got %h expected 0", rd); end
        wb_read(32'h44, rd);
        checks++; if (rd !== 32'h0) begin fails++; $display("FAIL reset_new: got %h expected 0", rd); end
        wb_read(32'h48, rd);
        checks++; if (rd !== 32'h0) begin fails++; $display("FAIL reset_err: got %h expected 0", rd); end
        wb_read(32'h00, rd);
        checks++; if (rd !== 32'h0) begin fails++; $display("FAIL reset_value0: got %h expected 0", rd); end
    endtask

    task automatic test_ch2_pulse();
        do_reset();
        wb_write(32'h4C, 32'h4, 4'hF);
        @(negedge clk); pwm[2] = 1'b1;
        repeat (1500 * CPU) @(negedge clk);
        pwm[2] = 1'b0;
        @(posedge clk);              // edge that first samples the low level
        repeat (4) @(posedge clk);   // VALUE/NEW land on this edge (SYNC_STAGES+2)
        @(negedge clk);
        checks++; if (irq !== 1'b0) begin fails++; $display("FAIL latency_early: irq got %b expected 0", irq); end
        @(posedge clk); @(negedge clk);
        checks++; if (irq !== 1'b1) begin fails++; $display("FAIL latency_irq: irq got %b expected 1", irq); end
        wb_read(32'h08, rd);
        checks++; if (rd < 32'd1499 || rd > 32'd1501) begin fails++; $display("FAIL ch2_value: got %h expected 05DC +-1", rd); end
        wb_read(32'h40, rd);
        checks++; if (rd !== 32'h4) begin fails++; $display("FAIL ch2_status: got %h expected 4", rd); end
        wb_read(32'h44, rd);
        checks++; if (rd !== 32'h4) begin fails++; $display("FAIL ch2_new: got %h expected 4", rd); end
        wb_read(32'h48, rd);
        checks++; if (rd !== 32'h0) begin fails++; $display("FAIL ch2_err: got %h expected 0", rd); end
    endtask

    task automatic test_long_pulse();
        do_reset();
        pulse(0, 3000);
        wb_read(32'h00, rd);
        checks++; if (rd !== 32'h89C4) begin fails++; $display("FAIL long_value: got %h expected 89c4", rd); end
        wb_read(32'h48, rd);
        checks++; if (rd[0] !== 1'b1) begin fails++; $display("FAIL long_err: got %b expected 1", rd[0]); end
        wb_read(32'h40, rd);
        checks++; if (rd[0] !== 1'b0) begin fails++; $display("FAIL long_status: got %b expected 0", rd[0]); end
        wb_read(32'h44, rd);
        checks++; if (rd[0] !== 1'b0) begin fails++; $display("FAIL long_new: got %b expected 0", rd[0]); end
        repeat (400) @(negedge clk);
        pulse(0, 1000);
        wb_read(32'h00, rd);
        checks++; if (rd < 32'd999 || rd > 32'd1001) begin fails++; $display("FAIL valid_value: got %h expected 03e8 +-1", rd); end
        wb_read(32'h48, rd);
        checks++; if (rd[0] !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b expected 1", rd[0]); end
        wb_read(32'h40, rd);
        checks++; if (rd[0] !== 1'b1) begin fails++; $display("FAIL valid_status: got %b expected 1", rd[0]); end
        wb_write(32'h48, 32'h1, 4'b0000);
        wb_read(32'h48, rd);
        checks++; if (rd[0] !== 1'b1) begin fails++; $display("FAIL err_sel_masked: got %b expected 1", rd[0]); end
        wb_write(32'h48, 32'h1, 4'b0001);
        wb_read(32'h48, rd);
        checks++; if (rd[0] !== 1'b0) begin fails++; $display("FAIL err_w1c: got %b expected 0", rd[0]); end
    endtask

    task automatic test_timeout();
        do_reset();
        repeat (3900 * CPU) @(negedge clk);
        wb_read(32'h04, rd);
        checks++; if (rd !== 32'h0) begin fails++; $display("FAIL pre_timeout_value: got %h expected 0", rd); end
        wb_read(32'h48, rd);
        checks++; if (rd[1] !== 1'b0) begin fails++; $display("FAIL pre_timeout_err: got %b expected 0", rd[1]); end
        repeat (200 * CPU) @(negedge clk);
        wb_read(32'h04, rd);
        checks++; if (rd !== 32'hC000) begin fails++; $display("FAIL timeout_value: got %h expected c000", rd); end
        wb_read(32'h48, rd);
        checks++; if (rd[1] !== 1'b1) begin fails++; $display("FAIL timeout_err: got %b expected 1", rd[1]); end
        wb_read(32'h40, rd);
        checks++; if (rd !== 32'h0) begin fails++; $display("FAIL timeout_status: got %h expected 0", rd); end
    endtask

    task automatic test_irq();
        do_reset();
        wb_write(32'h4C, 32'h2, 4'hF);
        @(negedge clk);
        checks++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_idle: got %b expected 0", irq); end
        pulse(1, 1000);
        checks++; if (irq !== 1'b1) begin fails++; $display("FAIL irq_set: got %b expected 1", irq); end
        @(negedge clk); pwm[1] = 1'b1;
        repeat (100 * CPU) @(negedge clk);
        pwm[1] = 1'b0;
        repeat (4) @(posedge clk);   // sampling edge k, then k+1..k+3
        @(negedge clk);
        adr = 32'h44; dat_w = 32'h2; sel = 4'hF; we = 1'b1; stb = 1'b1; cyc = 1'b1;
        @(posedge clk);              // edge k+4: W1C and new sample coincide
        @(negedge clk);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        checks++; if (ack !== 1'b1) begin fails++; $display("FAIL collide_ack: got %b expected 1", ack); end
        @(posedge clk); @(negedge clk);
        checks++; if (irq !== 1'b1) begin fails++; $display("FAIL irq_set_wins: got %b expected 1", irq); end
        wb_read(32'h44, rd);
        checks++; if (rd !== 32'h2) begin fails++; $display("FAIL new_set_wins: got %h expected 2", rd); end
        wb_read(32'h04, rd);
        checks++; if (rd < 32'd99 || rd > 32'd101) begin fails++; $display("FAIL ch1_value: got %h expected 0064 +-1", rd); end
        wb_write(32'h44, 32'h2, 4'hF);
        @(negedge clk);
        checks++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_clear: got %b expected 0", irq); end
        wb_read(32'h44, rd);
        checks++; if (rd !== 32'h0) begin fails++; $display("FAIL new_w1c: got %h expected 0", rd); end
    endtask

    task automatic test_map();
        do_reset();
        wb_read(32'h10, rd);
        checks++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL unused_slot: got %h expected deadbeef", rd); end
        wb_read(32'h50, rd);
        checks++; if (rd !== 32'h50570004) begin fails++; $display("FAIL id: got %h expected 50570004", rd); end
        wb_read(32'h7C, rd);
        checks++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL bad_addr: got %h expected deadbeef", rd); end
        wb_write(32'h40, 32'hF, 4'hF);
        checks++; if (ack_seen !== 1'b1) begin fails++; $display("FAIL ro_write_ack: got %b expected 1", ack_seen); end
        wb_read(32'h40, rd);
        checks++; if (rd !== 32'h0) begin fails++; $display("FAIL ro_write_ignored: got %h expected 0", rd); end
        wb_write(32'h4C, 32'hF, 4'b0010);
        wb_read(32'h4C, rd);
        checks++; if (rd !== 32'h0) begin fails++; $display("FAIL irq_en_lane: got %h expected 0", rd); end
        wb_write(32'h4C, 32'h5, 4'b0001);
        wb_read(32'h4C, rd);
        checks++; if (rd !== 32'h5) begin fails++; $display("FAIL irq_en_rw: got %h expected 5", rd); end
        checks++; if ({err, rty} !== 2'b00) begin fails++; $display("FAIL err_rty: got %b expected 00", {err, rty}); end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  pat;
        logic [31:0] first;
        pat = '0; first = '0;
        @(negedge clk);
        adr = 32'h50; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pat[i] = ack;
            if (i == 0) first = dat_r;
        end
        stb = 1'b0; cyc = 1'b0;
        checks++; if (pat !== 4'b0101) begin fails++; $display("FAIL ack_pattern: got %b expected 0101 (first cycle in bit 0)", pat); end
        checks++; if (first !== 32'h50570004) begin fails++; $display("FAIL ack_data: got %h expected 50570004", first); end
    endtask

    task automatic test_reset_mid_pulse();
        do_reset();
        wb_write(32'h4C, 32'hF, 4'hF);
        pulse(0, 500);
        checks++; if (irq !== 1'b1) begin fails++; $display("FAIL pre_reset_irq: got %b expected 1", irq); end
        @(negedge clk); pwm[3] = 1'b1;
        repeat (300 * CPU) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++; if ({irq, ack} !== 2'b00) begin fails++; $display("FAIL mid_reset_outputs: got %b expected 00", {irq, ack}); end
        rst = 1'b0;
        repeat (200 * CPU) @(negedge clk);
        pwm[3] = 1'b0;
        repeat (20) @(negedge clk);
        wb_read(32'h0C, rd);
        checks++; if (rd !== 32'h0) begin fails++; $display("FAIL tail_value3: got %h expected 0", rd); end
        wb_read(32'h00, rd);
        checks++; if (rd !== 32'h0) begin fails++; $display("FAIL mid_reset_value0: got %h expected 0", rd); end
        wb_read(32'h44, rd);
        checks++; if (rd !== 32'h0) begin fails++; $display("FAIL mid_reset_new: got %h expected 0", rd); end
        wb_read(32'h40, rd);
        checks++; if (rd !== 32'h0) begin fails++; $display("FAIL mid_reset_status: got %h expected 0", rd); end
        wb_read(32'h4C, rd);
        checks++; if (rd !== 32'h0) begin fails++; $display("FAIL mid_reset_irq_en: got %h expected 0", rd); end
        wb_read(32'h48, rd);
        checks++; if (rd !== 32'h0) begin fails++; $display("FAIL mid_reset_err: got %h expected 0", rd); end
    endtask

    initial begin
        test_reset();
        test_ch2_pulse();
        test_long_pulse();
        test_timeout();
        test_irq();
        test_map();
        test_back_to_back();
        test_reset_mid_pulse();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
